branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64, power of 2 (>=2), number of 2-bit prediction counters.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port f_pc  input  XLEN  fetch-stage PC for prediction lookup.
REQ-006 Port f_pred_taken  output  1  combinational prediction: MSB of counter at index(f_pc).
REQ-007 Port r_valid  input  1  resolve request valid; the unit is always ready (no backpressure).
REQ-008 Port r_b_control  input  3  branch type (encoding per REQ-013).
REQ-009 Port r_r1, r_r2  input  XLEN each  source operands.
REQ-010 Port r_pc  input  XLEN  PC of the resolving branch.
REQ-011 Port r_pred_taken  input  1  prediction originally used for this branch.
REQ-012 Ports o_valid, o_taken, o_mispredict, o_flush  output  1 each; o_branch_cnt, o_mispred_cnt  output  32 each.

Function
REQ-013 Encodings: 001 BEQ, 010 BNE, 011 BLT (signed), 100 BGE (signed), 101 BGEU, 111 BLTU; 000 and 110 are non-branch.
REQ-014 Index = PC[log2(BHT_ENTRIES)+1:2]; PC bits [1:0] are ignored.
REQ-015 Compare is combinational on r_* inputs; results are registered: latency exactly 1 cycle from r_valid to o_valid.
REQ-016 o_valid = r_valid of the previous cycle; o_taken/o_mispredict/o_flush are 0 whenever o_valid is 0.
REQ-017 Non-branch code with r_valid: o_valid=1, o_taken=0, o_mispredict=0, no counter update, no statistic increment.
REQ-018 Valid branch: o_taken = compare result; o_mispredict = o_taken XOR r_pred_taken; o_flush = o_mispredict.
REQ-019 Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken increments, saturates at 11; not-taken decrements, saturates at 00.
REQ-020 Counter write occurs on the same edge that registers the result; a lookup in the same cycle as the resolve sees the pre-update value; the next cycle sees the updated value.
REQ-021 o_branch_cnt increments per valid branch; o_mispred_cnt increments per mispredict; both saturate at 0xFFFFFFFF (no wrap).
REQ-022 Back-to-back resolves to the same index every cycle accumulate correctly (each update uses the latest stored value).
REQ-023 Signed compares treat operands as two's-complement XLEN-bit; unsigned compares as unsigned XLEN-bit.

Reset
REQ-024 rst_n low asynchronously sets all counters to 01, both statistics to 0, o_valid/o_taken/o_mispredict/o_flush to 0.
REQ-025 A resolve in flight when reset asserts is discarded; no update or count results from it.
REQ-026 First valid r_valid sampled after rst_n deasserts is processed normally.

Structure
REQ-027 Shared package branch_pkg holds the b_control encoding enum, counter-state constants, and default parameter values.
REQ-028 One sub-module branch_compare (combinational, parametrised by XLEN): b_control, r1, r2 -> taken; the unit instantiates it once.

Verification
REQ-029 BEQ r1=r2=0x5, pred=0 -> next cycle o_taken=1, o_mispredict=1, o_flush=1; counter at index(r_pc) 01->10.
REQ-030 BLT r1=0xFFFFFFFF, r2=1 -> taken; BLTU same operands -> not taken; BGEU 0x80000000 vs 0x7FFFFFFF -> taken.
REQ-031 Four consecutive taken BNE at r_pc=0x100 -> counter 01->10->11->11; f_pc=0x100 gives f_pred_taken=1 from the cycle after the first update.
REQ-032 f_pc=r_pc=0x40 in the same cycle, counter 01, taken branch -> f_pred_taken=0 that cycle, 1 the next cycle.
REQ-033 r_b_control=110 with r_valid -> o_valid=1, o_taken=0, o_branch_cnt unchanged, no counter update.
REQ-034 Assert rst_n low mid-stream with r_valid=1 -> outputs 0 immediately, counters 01, statistics 0; preload o_mispred_cnt=0xFFFFFFFF via force and mispredict -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: branch-type encoding,
// 2-bit predictor counter states and default sizing.
package branch_pkg;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_BHT_ENTRIES = 64;

  typedef enum logic [2:0] {
    BR_NONE0 = 3'b000,
    BR_BEQ   = 3'b001,
    BR_BNE   = 3'b010,
    BR_BLT   = 3'b011,
    BR_BGE   = 3'b100,
    BR_BGEU  = 3'b101,
    BR_NONE6 = 3'b110,
    BR_BLTU  = 3'b111
  } b_control_e;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  // True for the six encodings that are real conditional branches.
  function automatic logic is_branch(input logic [2:0] code);
    return (code != BR_NONE0) && (code != BR_NONE6);
  endfunction

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == CNT_STRONG_T) ? CNT_STRONG_T : cur + 2'd1;
    else       return (cur == CNT_STRONG_NT) ? CNT_STRONG_NT : cur - 2'd1;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation for one resolving branch.
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [2:0]      b_control,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            taken
);

  // Evaluate the condition selected by the branch type; non-branches never take.
  always_comb begin
    taken = 1'b0;
    case (b_control_e'(b_control))
      BR_BEQ:  taken = (r1 == r2);
      BR_BNE:  taken = (r1 != r2);
      BR_BLT:  taken = ($signed(r1) <  $signed(r2));
      BR_BGE:  taken = ($signed(r1) >= $signed(r2));
      BR_BGEU: taken = (r1 >= r2);
      BR_BLTU: taken = (r1 <  r2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves branches one cycle after request, trains a
// table of 2-bit counters used for fetch-time prediction, and keeps
// saturating branch / mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int BHT_ENTRIES = DEF_BHT_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            r_valid,
  input  logic [2:0]      r_b_control,
  input  logic [XLEN-1:0] r_r1,
  input  logic [XLEN-1:0] r_r2,
  input  logic [XLEN-1:0] r_pc,
  input  logic            r_pred_taken,
  output logic            o_valid,
  output logic            o_taken,
  output logic            o_mispredict,
  output logic            o_flush,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] r_idx;
  logic             cmp_taken;
  logic             is_br;
  logic             mispred_d;
  logic             valid_q, taken_q, mispred_q;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic             unused_pc_bits;

  // Word-aligned PCs: the two low bits never select a counter.
  assign f_idx = f_pc[IDX_W+1:2];
  assign r_idx = r_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0], r_pc[XLEN-1:IDX_W+2], r_pc[1:0]};

  // Prediction reads the stored counter directly, so a same-cycle resolve
  // to that index is only visible from the following cycle.
  assign f_pred_taken = bht_q[f_idx][1];

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .b_control (r_b_control),
    .r1        (r_r1),
    .r2        (r_r2),
    .taken     (cmp_taken)
  );

  assign is_br     = r_valid && is_branch(r_b_control);
  assign mispred_d = cmp_taken ^ r_pred_taken;

  assign branch_cnt_d  = (is_br && (branch_cnt_q != 32'hFFFF_FFFF)) ? branch_cnt_q + 32'd1
                                                                    : branch_cnt_q;
  assign mispred_cnt_d = (is_br && mispred_d && (mispred_cnt_q != 32'hFFFF_FFFF))
                         ? mispred_cnt_q + 32'd1 : mispred_cnt_q;

  // Counter table: every entry starts weakly not-taken; one entry trains per branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_WEAK_NT;
    end else if (is_br) begin
      bht_q[r_idx] <= ctr_next(bht_q[r_idx], cmp_taken);
    end
  end

  // Result registers: direction flags are forced low for non-branches and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      mispred_q <= 1'b0;
    end else begin
      valid_q   <= r_valid;
      taken_q   <= is_br && cmp_taken;
      mispred_q <= is_br && mispred_d;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_taken       = taken_q;
  assign o_mispredict  = mispred_q;
  assign o_flush       = mispred_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an abstract reference model
// and a per-cycle compare process.
module tb_branch_resolve_unit;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        r_valid;
  logic [2:0]  r_b_control;
  logic [31:0] r_r1, r_r2, r_pc;
  logic        r_pred_taken;
  logic        o_valid, o_taken, o_mispredict, o_flush;
  logic [31:0] o_branch_cnt, o_mispred_cnt;

  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;
  logic preload_mis = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_pc          (f_pc),
    .f_pred_taken  (f_pred_taken),
    .r_valid       (r_valid),
    .r_b_control   (r_b_control),
    .r_r1          (r_r1),
    .r_r2          (r_r2),
    .r_pc          (r_pc),
    .r_pred_taken  (r_pred_taken),
    .o_valid       (o_valid),
    .o_taken       (o_taken),
    .o_mispredict  (o_mispredict),
    .o_flush       (o_flush),
    .o_branch_cnt  (o_branch_cnt),
    .o_mispred_cnt (o_mispred_cnt)
  );

  // ---------------- reference model ----------------
  int          bht_m [N];
  logic        ev, et, em;
  logic [31:0] ebc, emc;

  function automatic bit m_is_br(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd4) || (c == 3'd5) || (c == 3'd7);
  endfunction

  // Conditions evaluated on 64-bit integers: sign- or zero-extend, then compare.
  function automatic bit m_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (c)
      3'd1:    return ua == ub;
      3'd2:    return ua != ub;
      3'd3:    return sa < sb;
      3'd4:    return sa >= sb;
      3'd5:    return ua >= ub;
      3'd7:    return ua < ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int m_step(input int cur, input bit t);
    if (t) return (cur >= 3) ? 3 : cur + 1;
    else   return (cur <= 0) ? 0 : cur - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bht_m[i] <= 1;
      ev  <= 1'b0;
      et  <= 1'b0;
      em  <= 1'b0;
      ebc <= 32'd0;
      emc <= 32'd0;
    end else begin
      ev <= r_valid;
      et <= r_valid && m_is_br(r_b_control) && m_taken(r_b_control, r_r1, r_r2);
      em <= r_valid && m_is_br(r_b_control) && (m_taken(r_b_control, r_r1, r_r2) != r_pred_taken);
      if (r_valid && m_is_br(r_b_control)) begin
        bht_m[m_idx(r_pc)] <= m_step(bht_m[m_idx(r_pc)], m_taken(r_b_control, r_r1, r_r2));
        if (ebc != 32'hFFFF_FFFF) ebc <= ebc + 32'd1;
        if ((m_taken(r_b_control, r_r1, r_r2) != r_pred_taken) && (emc != 32'hFFFF_FFFF))
          emc <= emc + 32'd1;
      end
      if (preload_mis) emc <= 32'hFFFF_FFFF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid",       {31'd0, o_valid},      {31'd0, ev});
      chk("o_taken",       {31'd0, o_taken},      {31'd0, et});
      chk("o_mispredict",  {31'd0, o_mispredict}, {31'd0, em});
      chk("o_flush",       {31'd0, o_flush},      {31'd0, em});
      chk("o_branch_cnt",  o_branch_cnt,  ebc);
      chk("o_mispred_cnt", o_mispred_cnt, emc);
      chk("f_pred_taken",  {31'd0, f_pred_taken}, {31'd0, (bht_m[m_idx(f_pc)] >= 2)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred);
    r_valid      = 1'b1;
    r_b_control  = c;
    r_r1         = a;
    r_r2         = b;
    r_pc         = pc;
    r_pred_taken = pred;
  endtask

  task automatic idle();
    r_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    f_pc = 32'd0;
    r_valid = 1'b0;
    r_b_control = 3'd0;
    r_r1 = 32'd0;
    r_r2 = 32'd0;
    r_pc = 32'd0;
    r_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_o_valid",   {31'd0, o_valid}, 32'd0);
    chk("rst_brcnt",     o_branch_cnt, 32'd0);
    chk("rst_miscnt",    o_mispred_cnt, 32'd0);
    chk("rst_ctr",       {30'd0, dut.bht_q[5]}, 32'd1);
    chk("rst_fpred",     {31'd0, f_pred_taken}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // BEQ equal, predicted not-taken: taken + mispredict, counter 01->10
    f_pc = 32'h280;
    drive(3'b001, 32'h5, 32'h5, 32'h280, 1'b0);
    step(); idle();
    chk("beq_taken",   {31'd0, o_taken}, 32'd1);
    chk("beq_mis",     {31'd0, o_mispredict}, 32'd1);
    chk("beq_flush",   {31'd0, o_flush}, 32'd1);
    chk("beq_ctr",     {30'd0, dut.bht_q[32]}, 32'd2);
    chk("beq_fpred",   {31'd0, f_pred_taken}, 32'd1);

    // Signed vs unsigned compares
    drive(3'b011, 32'hFFFF_FFFF, 32'h1, 32'h284, 1'b1);
    step();
    chk("blt_taken", {31'd0, o_taken}, 32'd1);
    drive(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h288, 1'b1);
    step();
    chk("bltu_taken", {31'd0, o_taken}, 32'd0);
    chk("bltu_mis",   {31'd0, o_mispredict}, 32'd1);
    drive(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h28C, 1'b0);
    step();
    chk("bgeu_taken", {31'd0, o_taken}, 32'd1);
    drive(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h290, 1'b0);
    step();
    chk("bge_taken", {31'd0, o_taken}, 32'd0);
    drive(3'b010, 32'h1234, 32'h1234, 32'h294, 1'b1);
    step(); idle();
    chk("bne_eq_taken", {31'd0, o_taken}, 32'd0);
    chk("brcnt_6", o_branch_cnt, 32'd6);

    // Back-to-back taken BNE on one index: 01->10->11->11
    f_pc = 32'h100;
    #1;
    chk("bne_fpred_pre", {31'd0, f_pred_taken}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(3'b010, 32'h1, 32'h2, 32'h100, 1'b0);
      step();
      chk("bne_ctr", {30'd0, dut.bht_q[0]}, (k == 0) ? 32'd2 : 32'd3);
      chk("bne_fpred", {31'd0, f_pred_taken}, 32'd1);
    end
    idle();

    // Same-cycle lookup sees the pre-update counter
    f_pc = 32'h40;
    drive(3'b001, 32'h7, 32'h7, 32'h40, 1'b0);
    #1;
    chk("same_cyc_fpred", {31'd0, f_pred_taken}, 32'd0);
    #1;
    step(); idle();
    chk("next_cyc_fpred", {31'd0, f_pred_taken}, 32'd1);

    // Non-branch codes: valid, never taken, nothing counted or trained
    drive(3'b110, 32'h1, 32'h1, 32'h3F0, 1'b1);
    step();
    chk("nb6_valid", {31'd0, o_valid}, 32'd1);
    chk("nb6_taken", {31'd0, o_taken}, 32'd0);
    chk("nb6_mis",   {31'd0, o_mispredict}, 32'd0);
    chk("nb6_brcnt", o_branch_cnt, 32'd11);
    drive(3'b000, 32'h1, 32'h1, 32'h3F0, 1'b1);
    step(); idle();
    chk("nb0_brcnt", o_branch_cnt, 32'd11);
    chk("nb_ctr",    {30'd0, dut.bht_q[60]}, 32'd1);

    // Low PC bits ignored for indexing
    f_pc = 32'h2F0;
    drive(3'b111, 32'h0, 32'h1, 32'h2F3, 1'b0);
    step(); idle();
    chk("lowbits_fpred", {31'd0, f_pred_taken}, 32'd1);

    // Not-taken saturation at strong-NT
    f_pc = 32'h400;
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, 32'h1, 32'h2, 32'h400, 1'b1);
      step();
    end
    idle();
    chk("nt_sat_ctr",   {30'd0, dut.bht_q[0]}, 32'd0);
    chk("nt_sat_fpred", {31'd0, f_pred_taken}, 32'd0);
    chk("brcnt_17",     o_branch_cnt, 32'd17);

    // Mispredict statistic saturates at all-ones
    chk_en = 1'b0;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    preload_mis = 1'b1;
    step();
    preload_mis = 1'b0;
    chk_en = 1'b1;
    drive(3'b001, 32'h1, 32'h1, 32'h500, 1'b0);
    step(); idle();
    chk("missat_mis", {31'd0, o_mispredict}, 32'd1);
    chk("missat_cnt", o_mispred_cnt, 32'hFFFF_FFFF);
    step();

    // Reset mid-stream with a request presented: discarded, then reprocessed
    f_pc = 32'h600;
    drive(3'b001, 32'h3, 32'h3, 32'h600, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    chk("mrst_valid",  {31'd0, o_valid}, 32'd0);
    chk("mrst_taken",  {31'd0, o_taken}, 32'd0);
    chk("mrst_flush",  {31'd0, o_flush}, 32'd0);
    chk("mrst_brcnt",  o_branch_cnt, 32'd0);
    chk("mrst_miscnt", o_mispred_cnt, 32'd0);
    chk("mrst_ctr",    {30'd0, dut.bht_q[0]}, 32'd1);
    step();
    rst_n = 1'b1;
    step(); idle();
    chk("post_rst_taken", {31'd0, o_taken}, 32'd1);
    chk("post_rst_brcnt", o_branch_cnt, 32'd1);
    chk("post_rst_ctr",   {30'd0, dut.bht_q[0]}, 32'd2);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
